// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the scratch-RAM arbiter.
// Round-robin contention handling is enabled by defining RAM_ARB_ROUND_ROBIN_EN.
package ram_arb_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 64;
  localparam int RAM_DEPTH = 256;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef logic req_id_t;

  // Read-return tag carried alongside the RAM access.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the 256x64 scratch RAM; zero-sweeps the RAM after reset or clr_req.
// Macro RAM_ARB_ROUND_ROBIN_EN: round-robin on contention; undefined gives fixed priority to requester 0.
//
// state    | meaning
// ST_CLEAR | sweeping zeros into every RAM word, no grants, busy=1
// ST_RUN   | arbitrating one access per cycle between requesters 0 and 1
module ram_arbiter
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q;

  logic    arb_en;
  logic    pick1;
  logic    acc;
  req_id_t acc_id;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  req_id_t rr_ptr_q, rr_ptr_d;

  assign pick1    = rr_ptr_q;
  assign rr_ptr_d = acc ? ~acc_id : rr_ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= 1'b0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick1 = 1'b0;
`endif

  assign arb_en = (state_q == ST_RUN) && !clr_req;
  assign m0_gnt = arb_en & m0_req & (~m1_req | ~pick1);
  assign m1_gnt = arb_en & m1_req & (~m0_req | pick1);
  assign acc    = m0_gnt | m1_gnt;
  assign acc_id = m1_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      cen_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(RAM_DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        clr_addr_d = '0;
        if (clr_req) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy   = (state_q == ST_CLEAR);
    cen_d  = 1'b0;
    wen_d  = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    tag1_d = '0;
    if (state_q == ST_CLEAR) begin
      cen_d  = 1'b1;
      wen_d  = 1'b1;
      addr_d = clr_addr_q;
      din_d  = '0;
    end else if (acc) begin
      cen_d       = 1'b1;
      wen_d       = acc_id ? m1_wr : m0_wr;
      addr_d      = acc_id ? m1_addr : m0_addr;
      din_d       = wen_d ? (acc_id ? m1_wdata : m0_wdata) : '0;
      tag1_d.valid = ~wen_d;
      tag1_d.id    = acc_id;
    end
  end

  assign cen       = cen_q;
  assign wen       = wen_q;
  assign s_addr    = addr_q;
  assign s_din     = din_q;
  assign m0_rvalid = tag2_q.valid & ~tag2_q.id;
  assign m1_rvalid = tag2_q.valid & tag2_q.id;
  // Both ports see the RAM output; rvalid says whose it is.
  assign m0_rdata  = s_dout;
  assign m1_rdata  = s_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: RAM model, table vectors, corner sequences and random traffic.
module tb_ram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        clr_req;
  logic        busy;
  logic        m0_req, m0_wr, m0_gnt, m0_rvalid;
  logic [7:0]  m0_addr;
  logic [63:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_gnt, m1_rvalid;
  logic [7:0]  m1_addr;
  logic [63:0] m1_wdata, m1_rdata;
  logic        cen, wen;
  logic [7:0]  s_addr;
  logic [63:0] s_din, s_dout;

  ram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .clr_req(clr_req), .busy(busy),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cen(cen), .wen(wen), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM.
  logic [63:0] ram [256];
  initial s_dout = '0;
  always @(posedge clk) begin
    if (cen) begin
      if (wen) ram[s_addr] <= s_din;
      else     s_dout      <= ram[s_addr];
    end
  end

  typedef struct packed {
    logic        r0; logic w0; logic [7:0] a0; logic [63:0] d0;
    logic        r1; logic w1; logic [7:0] a1; logic [63:0] d1;
    logic        clr;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [1:0] exp_rr;   // {gnt0, gnt1}
    logic [1:0] exp_fx;
  } vec_t;

  typedef struct {
    int          due;
    bit          id;
    logic [63:0] data;
  } rsp_t;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          clear_left;
  int          edge_n;
  bit          pref;
  logic        exp_cen, exp_wen;
  logic [7:0]  exp_addr;
  logic [63:0] exp_din;
  logic [63:0] mem_ref [256];
  rsp_t        rq [$];
  logic        g0_s, g1_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [63:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [63:0] d1, input logic clr);
    stim_t s;
    s.r0 = r0; s.w0 = w0; s.a0 = a0; s.d0 = d0;
    s.r1 = r1; s.w1 = w1; s.a1 = a1; s.d1 = d1;
    s.clr = clr;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
  endfunction

  task automatic mdl_reset();
    clear_left = 256;
    pref       = 1'b0;
    exp_cen    = 1'b0;
    exp_wen    = 1'b0;
    exp_addr   = '0;
    exp_din    = '0;
    rq.delete();
  endtask

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step(input stim_t s);
    int          g;
    bit          ev0, ev1;
    logic [63:0] ed;
    rsp_t        r;
    m0_req = s.r0; m0_wr = s.w0; m0_addr = s.a0; m0_wdata = s.d0;
    m1_req = s.r1; m1_wr = s.w1; m1_addr = s.a1; m1_wdata = s.d1;
    clr_req = s.clr;
    #1;
    g = -1;
    if (clear_left == 0 && !s.clr) begin
      if (s.r0 && s.r1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        g = int'(pref);
`else
        g = 0;
`endif
      end else if (s.r0) g = 0;
      else if (s.r1) g = 1;
    end
    chk("busy", busy, clear_left > 0);
    chk("m0_gnt", m0_gnt, g == 0);
    chk("m1_gnt", m1_gnt, g == 1);
    g0_s = m0_gnt;
    g1_s = m1_gnt;
    @(posedge clk);
    #1;
    edge_n++;
    if (clear_left > 0) begin
      exp_cen  = 1'b1;
      exp_wen  = 1'b1;
      exp_addr = 8'(256 - clear_left);
      exp_din  = '0;
      clear_left--;
    end else if (s.clr) begin
      exp_cen    = 1'b0;
      exp_wen    = 1'b0;
      clear_left = 256;
      foreach (mem_ref[i]) mem_ref[i] = '0;
    end else if (g >= 0) begin
      exp_cen  = 1'b1;
      exp_wen  = (g == 1) ? s.w1 : s.w0;
      exp_addr = (g == 1) ? s.a1 : s.a0;
      exp_din  = exp_wen ? ((g == 1) ? s.d1 : s.d0) : 64'h0;
      if (exp_wen) mem_ref[exp_addr] = exp_din;
      else         rq.push_back('{due: edge_n + 1, id: (g == 1), data: mem_ref[exp_addr]});
      pref = (g == 0);
    end else begin
      exp_cen = 1'b0;
      exp_wen = 1'b0;
    end
    chk("cen", cen, exp_cen);
    chk("wen", wen, exp_wen);
    chk("s_addr", s_addr, exp_addr);
    chk("s_din", s_din, exp_din);
    ev0 = 1'b0; ev1 = 1'b0; ed = '0;
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      r = rq.pop_front();
      ev0 = !r.id;
      ev1 = r.id;
      ed  = r.data;
    end
    chk("m0_rvalid", m0_rvalid, ev0);
    chk("m1_rvalid", m1_rvalid, ev1);
    if (ev0) chk("m0_rdata", m0_rdata, ed);
    if (ev1) chk("m1_rdata", m1_rdata, ed);
    @(negedge clk);
  endtask

  task automatic count_busy(input stim_t s, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      n++;
      step(s);
    end
  endtask

  task automatic add_vec(input stim_t s, input logic [1:0] err, input logic [1:0] efx);
    vec_t v;
    v.s = s; v.exp_rr = err; v.exp_fx = efx;
    vecs.push_back(v);
  endtask

  vec_t vecs [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [1:0]  e;
    stim_t       s;
    edge_n  = 0;
    reset_n = 1'b0;
    s = mk(1'b1, 1'b0, 8'h01, 64'h0, 1'b1, 1'b0, 8'h02, 64'h0, 1'b0);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h01; m0_wdata = '0;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h02; m1_wdata = '0;
    clr_req = 1'b0;
    mdl_reset();
    foreach (mem_ref[i]) mem_ref[i] = '0;
    repeat (3) @(negedge clk);

    chk("rst_cen", cen, 1'b0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_s_addr", s_addr, 8'h00);
    chk("rst_s_din", s_din, 64'h0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);

    // Initial sweep with both requesters knocking.
    reset_n = 1'b1;
    count_busy(s, n);
    chk("sweep_len", n, 256);

    add_vec(mk(0, 0, 8'h00, 64'h0, 1, 0, 8'h05, 64'h0, 0), 2'b01, 2'b01);
    add_vec(idle(), 2'b00, 2'b00);
    add_vec(idle(), 2'b00, 2'b00);
    add_vec(mk(1, 1, 8'h03, 64'h78, 0, 0, 8'h00, 64'h0, 0), 2'b10, 2'b10);
    add_vec(mk(1, 0, 8'h03, 64'h0, 0, 0, 8'h00, 64'h0, 0), 2'b10, 2'b10);
    add_vec(mk(1, 1, 8'h10, 64'h1234, 0, 0, 8'h00, 64'h0, 0), 2'b10, 2'b10);
    add_vec(mk(0, 0, 8'h00, 64'h0, 1, 1, 8'h20, 64'hBEEF, 0), 2'b01, 2'b01);
    add_vec(mk(1, 0, 8'h10, 64'h0, 1, 0, 8'h20, 64'h0, 0), 2'b10, 2'b10);
    add_vec(mk(1, 0, 8'h10, 64'h0, 1, 0, 8'h20, 64'h0, 0), 2'b01, 2'b10);
    add_vec(mk(1, 0, 8'h10, 64'h0, 1, 0, 8'h20, 64'h0, 0), 2'b10, 2'b10);
    add_vec(mk(1, 0, 8'h10, 64'h0, 1, 0, 8'h20, 64'h0, 0), 2'b01, 2'b10);
    add_vec(idle(), 2'b00, 2'b00);
    add_vec(idle(), 2'b00, 2'b00);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      e = vecs[i].exp_rr;
`else
      e = vecs[i].exp_fx;
`endif
      chk($sformatf("tbl_gnt[%0d]", i), {g0_s, g1_s}, e);
    end

    // Read in flight across clr_req, then confirm the sweep erased the RAM.
    step(mk(1, 1, 8'h07, 64'hAA, 0, 0, 8'h00, 64'h0, 0));
    step(mk(0, 0, 8'h00, 64'h0, 1, 0, 8'h07, 64'h0, 0));
    chk("clr_pre_gnt1", g1_s, 1'b1);
    step(mk(1, 0, 8'h07, 64'h0, 0, 0, 8'h00, 64'h0, 1));
    chk("clr_no_gnt", {g0_s, g1_s}, 2'b00);
    chk("clr_m1_rvalid", m1_rvalid, 1'b1);
    chk("clr_m1_rdata", m1_rdata, 64'hAA);
    count_busy(idle(), n);
    chk("clr_sweep_len", n, 256);
    step(mk(1, 0, 8'h07, 64'h0, 0, 0, 8'h00, 64'h0, 0));
    step(idle());
    chk("post_clr_rvalid", m0_rvalid, 1'b1);
    chk("post_clr_rdata", m0_rdata, 64'h0);
    step(idle());

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      s = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
             {$urandom(), $urandom()},
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
             {$urandom(), $urandom()},
             1'($urandom_range(0, 99) == 0));
      step(s);
    end

    // Reset asserted mid-sweep at clear address 100.
    reset_n = 1'b0;
    mdl_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (exp_cen && exp_addr == 8'd100) break;
      step(idle());
    end
    chk("midclr_addr", s_addr, 8'd100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_cen", cen, 1'b0);
    chk("async_wen", wen, 1'b0);
    chk("async_s_addr", s_addr, 8'h00);
    chk("async_busy", busy, 1'b1);
    mdl_reset();
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(idle(), n);
    chk("restart_sweep_len", n, 256);

    // Reset while a read is in flight drops its response.
    step(mk(1, 0, 8'h10, 64'h0, 0, 0, 8'h00, 64'h0, 0));
    #2;
    reset_n = 1'b0;
    mdl_reset();
    @(posedge clk);
    #1;
    chk("drop_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    count_busy(idle(), n);
    chk("drop_sweep_len", n, 256);
    step(mk(0, 0, 8'h00, 64'h0, 1, 0, 8'h10, 64'h0, 0));
    step(idle());
    step(idle());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
